block_memory: RTL



---
 rtl/block_memory_pkg.sv | 21 ++
 rtl/block_memory_ram.sv | 27 ++
 rtl/block_memory.sv | 112 +++++++++++
 3 files changed

// File: rtl/block_memory_pkg.sv
// Shared types and width helpers for the block-granular backing memory.
package block_memory_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Ceiling log2, never below one bit, so degenerate sizes still yield legal vectors.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/block_memory_ram.sv
// Line storage: one synchronous write port and a registered read port, contents never reset.
module block_memory_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 128,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/block_memory.sv
// Fixed-latency line memory behind the data cache: accepts one read/write per line,
// stays busy DELAY cycles, then returns the line with a one-cycle valid pulse or commits the write.
module block_memory
  import block_memory_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    mem_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout
);

  localparam int DATA_W = BLOCK_SIZE * 8;
  localparam int IDX_W  = clog2_min1(NUM_BLOCKS);
  localparam int CNT_W  = clog2_min1(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  op_t                op_reg, op_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               valid_reg;
  logic               have_data_reg;
  logic               ram_we;
  logic               ram_re;
  logic [DATA_W-1:0]  ram_rdata;

  // Only the low index bits select a line; the rest of the block address is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:IDX_W];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (is_input_valid && (mem_read || mem_write)) begin
          state_next = ST_BUSY;
          cnt_next   = CNT_LOAD;
          idx_next   = addr[IDX_W-1:0];
          op_next    = mem_write ? OP_WRITE : OP_READ;
          data_next  = din;
        end
      end
      ST_BUSY: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
          ram_we     = (op_reg == OP_WRITE);
          ram_re     = (op_reg == OP_READ);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      op_reg        <= OP_READ;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      have_data_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      valid_reg     <= ram_re;
      have_data_reg <= have_data_reg | ram_re;
    end
  end

  block_memory_ram #(
    .DEPTH (NUM_BLOCKS),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx_reg),
    .wdata (data_reg),
    .re    (ram_re),
    .raddr (idx_reg),
    .rdata (ram_rdata)
  );

  // The RAM output register is not reset, so dout reads as zero until a read has completed.
  assign mem_ready       = (state_reg == ST_IDLE);
  assign is_output_valid = valid_reg;
  assign dout            = have_data_reg ? ram_rdata : '0;

endmodule
